// File: rtl/writeback_arbiter_pkg.sv
// rtl/writeback_arbiter_pkg.sv - shared widths, defaults and payload type for the writeback stage
package writeback_arbiter_pkg;

   // Core and register file widths
   localparam int REGISTER_WIDTH              = 32;
   localparam int CPU_REGISTER_INDEX_WIDTH    = 5;
   localparam int REGISTER_FILE_NUMBER_OF_REG = 32;

   // Writeback defaults
   localparam int WB_FIFO_DEPTH     = 2;
   localparam int WB_STARVE_LIMIT   = 4;
   localparam int WB_FIFO_PTR_WIDTH = $clog2(WB_FIFO_DEPTH);

   typedef logic [CPU_REGISTER_INDEX_WIDTH-1:0] reg_idx_t;
   typedef logic [REGISTER_WIDTH-1:0]           reg_data_t;
   typedef logic [REGISTER_FILE_NUMBER_OF_REG-1:0] reg_mask_t;

   // One buffered long-latency result
   typedef struct packed {
      reg_idx_t  rd;
      reg_data_t data;
   } wb_entry_t;

   // One-hot register mask for a destination index
   function automatic reg_mask_t rd_mask(input reg_idx_t rd);
      reg_mask_t m;
      m     = '0;
      m[rd] = 1'b1;
      return m;
   endfunction

endpackage

// File: rtl/writeback_arbiter_wb_fifo.sv
// rtl/writeback_arbiter_wb_fifo.sv - synchronous {rd,data} FIFO for long-latency results
module wb_fifo
   import writeback_arbiter_pkg::*;
#(
   parameter int DEPTH = WB_FIFO_DEPTH
)(
   input  logic      clk,
   input  logic      rst_n,
   input  logic      i_push,
   input  wb_entry_t i_data,
   input  logic      i_pop,
   output wb_entry_t o_head,
   output logic      o_full,
   output logic      o_empty
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   wb_entry_t      r_mem [DEPTH];
   logic [PW-1:0]  r_wr_ptr;
   logic [PW-1:0]  r_rd_ptr;
   logic [PW:0]    r_count;
   logic           w_do_push;
   logic           w_do_pop;

   assign o_full    = (r_count == (PW+1)'(DEPTH));
   assign o_empty   = (r_count == '0);
   assign w_do_push = i_push && !o_full;
   assign w_do_pop  = i_pop && !o_empty;
   assign o_head    = r_mem[r_rd_ptr];

   // Payload storage; contents are meaningless while empty so no reset is needed
   always_ff @(posedge clk) begin
      if (w_do_push) begin
         r_mem[r_wr_ptr] <= i_data;
      end
   end

   // Binary pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
         case ({w_do_push, w_do_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
      end
   end

endmodule

// File: rtl/writeback_arbiter.sv
// rtl/writeback_arbiter.sv - merges ALU and long-latency results onto the register file write port
module writeback_arbiter
   import writeback_arbiter_pkg::*;
#(
   parameter int FIFO_DEPTH   = WB_FIFO_DEPTH,
   parameter int STARVE_LIMIT = WB_STARVE_LIMIT
)(
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic                                   alu_valid,
   input  logic [CPU_REGISTER_INDEX_WIDTH-1:0]    alu_rd,
   input  logic [REGISTER_WIDTH-1:0]              alu_data,
   input  logic                                   lsu_valid,
   output logic                                   lsu_ready,
   input  logic [CPU_REGISTER_INDEX_WIDTH-1:0]    lsu_rd,
   input  logic [REGISTER_WIDTH-1:0]              lsu_data,
   input  logic                                   issue_en,
   input  logic [CPU_REGISTER_INDEX_WIDTH-1:0]    issue_rd,
   output logic [REGISTER_FILE_NUMBER_OF_REG-1:0] busy,
   output logic                                   stall_req,
   output logic                                   write_en,
   output logic [CPU_REGISTER_INDEX_WIDTH-1:0]    write_rd,
   output logic [REGISTER_WIDTH-1:0]              data_in
);

   localparam int AGE_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [AGE_W-1:0] AGE_MAX  = AGE_W'(STARVE_LIMIT);
   localparam logic [AGE_W-1:0] AGE_TRIP = AGE_W'(STARVE_LIMIT - 1);

   wb_entry_t  w_head;
   wb_entry_t  w_in;
   logic       w_full;
   logic       w_empty;
   logic       w_push;
   logic       w_pop;
   reg_mask_t  w_set;
   reg_mask_t  w_clr;

   logic [AGE_W-1:0] r_age;
   logic             r_stall_req;
   reg_mask_t        r_busy;
   logic             r_write_en;
   reg_idx_t         r_write_rd;
   reg_data_t        r_data_in;

   // The ALU path cannot be stalled, so the FIFO only drains in ALU-idle cycles
   assign w_push    = lsu_valid && !w_full;
   assign w_pop     = !alu_valid && !w_empty;
   assign lsu_ready = !w_full;
   assign w_in      = '{rd: lsu_rd, data: lsu_data};

   assign w_clr = w_pop ? rd_mask(w_head.rd) : '0;
   assign w_set = (issue_en && (issue_rd != '0)) ? rd_mask(issue_rd) : '0;

   assign busy      = r_busy;
   assign stall_req = r_stall_req;
   assign write_en  = r_write_en;
   assign write_rd  = r_write_rd;
   assign data_in   = r_data_in;

   wb_fifo #(
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_push  (w_push),
      .i_data  (w_in),
      .i_pop   (w_pop),
      .o_head  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   // Head age: cleared on pop or while empty, otherwise counts up and saturates
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_age <= '0;
      end else if (w_pop || w_empty) begin
         r_age <= '0;
      end else if (r_age != AGE_MAX) begin
         r_age <= r_age + 1'b1;
      end
   end

   // Ask upstream to idle the ALU next cycle once the head has waited long enough
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_stall_req <= 1'b0;
      end else begin
         r_stall_req <= alu_valid && !w_empty && (r_age >= AGE_TRIP);
      end
   end

   // Pending-write scoreboard; a same-cycle issue overrides the pop clear
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_busy <= '0;
      end else begin
         r_busy <= (r_busy & ~w_clr) | w_set;
      end
   end

   // Write port register; rd=0 results are consumed without enabling the write
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_write_en <= 1'b0;
         r_write_rd <= '0;
         r_data_in  <= '0;
      end else if (alu_valid) begin
         r_write_en <= (alu_rd != '0);
         r_write_rd <= alu_rd;
         r_data_in  <= alu_data;
      end else if (w_pop) begin
         r_write_en <= (w_head.rd != '0);
         r_write_rd <= w_head.rd;
         r_data_in  <= w_head.data;
      end else begin
         r_write_en <= 1'b0;
      end
   end

endmodule

// File: tb/tb_writeback_arbiter.sv
// tb/tb_writeback_arbiter.sv - randomized and directed check of writeback_arbiter against a queue model
module tb_writeback_arbiter;

   localparam int DEPTH = 2;
   localparam int LIMIT = 4;

   logic        clk;
   logic        rst_n;
   logic        alu_valid;
   logic [4:0]  alu_rd;
   logic [31:0] alu_data;
   logic        lsu_valid;
   logic        lsu_ready;
   logic [4:0]  lsu_rd;
   logic [31:0] lsu_data;
   logic        issue_en;
   logic [4:0]  issue_rd;
   logic [31:0] busy;
   logic        stall_req;
   logic        write_en;
   logic [4:0]  write_rd;
   logic [31:0] data_in;

   writeback_arbiter #(
      .FIFO_DEPTH   (DEPTH),
      .STARVE_LIMIT (LIMIT)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .alu_valid (alu_valid),
      .alu_rd    (alu_rd),
      .alu_data  (alu_data),
      .lsu_valid (lsu_valid),
      .lsu_ready (lsu_ready),
      .lsu_rd    (lsu_rd),
      .lsu_data  (lsu_data),
      .issue_en  (issue_en),
      .issue_rd  (issue_rd),
      .busy      (busy),
      .stall_req (stall_req),
      .write_en  (write_en),
      .write_rd  (write_rd),
      .data_in   (data_in)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [4:0]  rd;
      logic [31:0] data;
   } ent_t;

   ent_t        m_q[$];
   logic [31:0] m_busy;
   int          m_age;
   logic        m_stall;
   int          n_vec;
   int          n_err;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_clear();
      m_q.delete();
      m_busy  = '0;
      m_age   = 0;
      m_stall = 1'b0;
   endtask

   // One clock: drive at posedge+1, check lsu_ready before the edge, check outputs after it
   task automatic step(input logic av, input logic [4:0] ar, input logic [31:0] ad,
                       input logic lv, input logic [4:0] lr, input logic [31:0] ld,
                       input logic ie, input logic [4:0] ir);
      int          occ;
      logic        push;
      logic        pop;
      ent_t        head;
      logic        exp_we;
      logic [4:0]  exp_rd;
      logic [31:0] exp_data;
      alu_valid = av; alu_rd = ar; alu_data = ad;
      lsu_valid = lv; lsu_rd = lr; lsu_data = ld;
      issue_en  = ie; issue_rd = ir;
      #1;
      occ = m_q.size();
      check_eq("lsu_ready", {63'd0, lsu_ready}, {63'd0, (occ < DEPTH)});
      push = lv && (occ < DEPTH);
      pop  = !av && (occ > 0);
      head = '{rd: 5'd0, data: 32'd0};
      if (occ > 0) head = m_q[0];
      exp_we = 1'b0; exp_rd = 5'd0; exp_data = 32'd0;
      if (av) begin
         exp_we = (ar != 0); exp_rd = ar; exp_data = ad;
      end else if (pop) begin
         exp_we = (head.rd != 0); exp_rd = head.rd; exp_data = head.data;
      end
      m_stall = av && (occ > 0) && (m_age >= LIMIT - 1);
      if (pop || occ == 0) m_age = 0;
      else if (m_age < LIMIT) m_age = m_age + 1;
      if (pop) begin
         m_busy[head.rd] = 1'b0;
         void'(m_q.pop_front());
      end
      if (ie && ir != 0) m_busy[ir] = 1'b1;
      if (push) m_q.push_back('{rd: lr, data: ld});
      @(posedge clk);
      #1;
      check_eq("write_en", {63'd0, write_en}, {63'd0, exp_we});
      if (exp_we) begin
         check_eq("write_rd", {59'd0, write_rd}, {59'd0, exp_rd});
         check_eq("data_in", {32'd0, data_in}, {32'd0, exp_data});
      end
      check_eq("busy", {32'd0, busy}, {32'd0, m_busy});
      check_eq("stall_req", {63'd0, stall_req}, {63'd0, m_stall});
   endtask

   task automatic idle();
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
   endtask

   initial begin
      n_vec = 0;
      n_err = 0;
      model_clear();
      rst_n = 1'b0;
      alu_valid = 0; alu_rd = 0; alu_data = 0;
      lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
      issue_en = 0; issue_rd = 0;
      #12;
      check_eq("rst_write_en", {63'd0, write_en}, 64'd0);
      check_eq("rst_write_rd", {59'd0, write_rd}, 64'd0);
      check_eq("rst_data_in", {32'd0, data_in}, 64'd0);
      check_eq("rst_busy", {32'd0, busy}, 64'd0);
      check_eq("rst_stall", {63'd0, stall_req}, 64'd0);
      check_eq("rst_lsu_ready", {63'd0, lsu_ready}, 64'd1);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Single ALU write to x5
      step(1'b1, 5'd5, 32'h12345678, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
      check_eq("alu_x5_rd", {59'd0, write_rd}, 64'd5);
      check_eq("alu_x5_data", {32'd0, data_in}, 64'h12345678);

      // Issue x3, long-latency result later, written one cycle after acceptance
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd3);
      check_eq("busy3_issued", {63'd0, busy[3]}, 64'd1);
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'hDEADBEEF, 1'b0, 5'd0);
      check_eq("busy3_queued", {63'd0, busy[3]}, 64'd1);
      check_eq("lsu_x3_no_bypass", {63'd0, write_en}, 64'd0);
      idle();
      check_eq("lsu_x3_data", {32'd0, data_in}, 64'hDEADBEEF);
      check_eq("busy3_cleared", {63'd0, busy[3]}, 64'd0);

      // ALU every cycle, two LSU pushes fill the FIFO, starvation forces a drain
      step(1'b1, 5'd10, 32'hA0, 1'b1, 5'd11, 32'hB0, 1'b0, 5'd0);
      step(1'b1, 5'd10, 32'hA1, 1'b1, 5'd12, 32'hB1, 1'b0, 5'd0);
      check_eq("full_lsu_ready", {63'd0, lsu_ready}, 64'd0);
      for (int i = 0; i < 8; i++) begin
         if (m_stall) step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
         else         step(1'b1, 5'd10, 32'hA2 + i, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
      end
      repeat (3) idle();

      // rd=0 from both paths never enables a write
      step(1'b1, 5'd0, 32'h11, 1'b1, 5'd0, 32'h22, 1'b0, 5'd0);
      idle();
      check_eq("x0_pop_no_write", {63'd0, write_en}, 64'd0);
      idle();

      // Issue of x7 in the same cycle as the x7 pop keeps busy[7]
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h77, 1'b0, 5'd0);
      step(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7);
      check_eq("busy7_set_wins", {63'd0, busy[7]}, 64'd1);
      step(1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'h78, 1'b0, 5'd0);
      idle();

      // Asynchronous reset with two entries queued
      step(1'b1, 5'd13, 32'hC0, 1'b1, 5'd14, 32'hD0, 1'b1, 5'd14);
      step(1'b1, 5'd13, 32'hC1, 1'b1, 5'd15, 32'hD1, 1'b1, 5'd15);
      alu_valid = 0; lsu_valid = 0; issue_en = 0;
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("arst_lsu_ready", {63'd0, lsu_ready}, 64'd1);
      check_eq("arst_busy", {32'd0, busy}, 64'd0);
      check_eq("arst_write_en", {63'd0, write_en}, 64'd0);
      check_eq("arst_stall", {63'd0, stall_req}, 64'd0);
      model_clear();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      repeat (3) begin
         idle();
         check_eq("arst_no_stale_write", {63'd0, write_en}, 64'd0);
      end

      // Randomized traffic honoring stall and WAW rules
      for (int i = 0; i < 3000; i++) begin
         logic        av;
         logic [4:0]  ar;
         av = ($urandom_range(0, 99) < 60) && !m_stall;
         ar = 5'($urandom_range(0, 31));
         if (m_busy[ar]) ar = 5'd0;
         step(av, ar, $urandom,
              ($urandom_range(0, 99) < 45), 5'($urandom_range(0, 31)), $urandom,
              ($urandom_range(0, 99) < 30), 5'($urandom_range(0, 31)));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/writeback_arbiter.md
# writeback_arbiter

Writeback stage that drives the register file write port. Merges results from the single-cycle ALU path and the long-latency load/multiply path into one write per cycle. Buffers long-latency results in a small FIFO and keeps a per-register pending scoreboard for issue-stage hazard checks. Sits between the execute/memory units and `register_file`, and is the sole owner of `write_en`, `write_rd` and `data_in`.

## Interface
- `FIFO_DEPTH`, default 2: long-latency result buffer entries; power of two, ≥2.
- `STARVE_LIMIT`, default 4: cycles a FIFO head may wait before a stall is requested.
- `clk` in 1: clock; all state updates on the rising edge.
- `rst_n` in 1: one clock; reset is asynchronous and active-low.
- `alu_valid` in 1: ALU result present this cycle; no back-pressure possible.
- `alu_rd` in `CPU_REGISTER_INDEX_WIDTH`: ALU destination.
- `alu_data` in `REGISTER_WIDTH`: ALU result.
- `lsu_valid` in 1: long-latency result offered.
- `lsu_ready` out 1: result accepted when `lsu_valid && lsu_ready`.
- `lsu_rd` in `CPU_REGISTER_INDEX_WIDTH`: long-latency destination.
- `lsu_data` in `REGISTER_WIDTH`: long-latency result.
- `issue_en` in 1: a long-latency instruction issued this cycle.
- `issue_rd` in `CPU_REGISTER_INDEX_WIDTH`: its destination.
- `busy` out `REGISTER_FILE_NUMBER_OF_REG`: bit i set while a long-latency write to xi is outstanding.
- `stall_req` out 1: upstream must hold `alu_valid` low in the following cycle.
- `write_en` out 1: register file write enable.
- `write_rd` out `CPU_REGISTER_INDEX_WIDTH`: register file write index.
- `data_in` out `REGISTER_WIDTH`: register file write data.

## Operation
- FIFO accepts the long-latency handshake. `lsu_ready = !full`, driven combinationally from FIFO state.
- Arbitration each cycle:
  - `alu_valid=1`: the ALU result is registered onto the write port.
  - `alu_valid=0` and FIFO non-empty: the FIFO head is popped and registered onto the write port.
  - Otherwise: `write_en` is 0 in the next cycle.
- Push and pop in the same cycle are allowed when the FIFO is not full. Occupancy is unchanged and the pointers wrap modulo `FIFO_DEPTH`.
- An empty FIFO does not bypass: a long-latency result is always pushed before it can be written.
- Starvation guard:
  - Head-age counter resets to 0 on any pop or when the FIFO is empty; otherwise it increments, saturating at `STARVE_LIMIT`.
  - `stall_req` is registered and set when age reaches `STARVE_LIMIT-1` with `alu_valid=1`.
  - The pop is guaranteed in the next cycle.
- Scoreboard:
  - `issue_en` sets `busy[issue_rd]`.
  - A long-latency pop clears `busy[rd]`.
  - If set and clear hit the same rd in one cycle, set wins.
  - `busy[0]` is never set.
- rd=0 handling:
  - A winning ALU or FIFO entry with rd=0 is consumed, but `write_en` stays 0.
  - A FIFO pop with rd=0 still counts as a pop.
- Upstream guarantees it never issues an ALU write to a register whose `busy` bit is set (WAW ordering).
- Asynchronous reset mid-operation discards FIFO contents, clears the scoreboard and the age counter, and deasserts all outputs immediately.

## Timing
- Reset values:
  - `write_en=0`, `write_rd=0`, `data_in=0`, `busy=0`, `stall_req=0`.
  - `lsu_ready=1` once the FIFO is empty.
- ALU result at edge N appears on the write port after edge N. The register file captures it at edge N+1.
- Long-latency result accepted at edge N with no ALU contention: written out after edge N+1 (FIFO latency of 1). `busy` clears after edge N+1.
- `stall_req` asserted after edge N forces a pop at edge N+1.

## Structure
- Shared widths come from `core.h` and `register_file.h`.
- New `writeback.h` holds the default `FIFO_DEPTH`, the default `STARVE_LIMIT` and the FIFO pointer width.
- One sub-module, `wb_fifo`: a synchronous FIFO with `full`/`empty`, a one-hot-free binary pointer and a stored `{rd,data}` payload.
- Arbitration, the age counter and the scoreboard live in `writeback_arbiter`.

## Test plan
- Reset, then single ALU result (x5, 0x12345678): write port shows `write_en=1`, `write_rd=5`, `data_in=0x12345678` one cycle later.
- Issue x3, then LSU (x3, 0xDEADBEEF) with no ALU traffic: `busy[3]` is 1 from issue until the write cycle; data written one cycle after acceptance.
- ALU valid every cycle and LSU pushes 2 entries: `lsu_ready=0` when full. `stall_req` is asserted after 4 cycles of head age; the head is written on the stall cycle and `lsu_ready` returns to 1.
- ALU result to x0 and LSU result to x0: `write_en` stays 0 and the FIFO drains normally.
- `issue_en` for x7 in the same cycle as the x7 pop: `busy[7]` remains 1.
- Reset asserted with 2 entries queued: `lsu_ready=1`, `busy=0`, `write_en=0` immediately; no queued data is written after release.
